// File: rtl/fpu_issue_ctrl_if.sv
// Handshake bundle between the FPU decode stage, the FPU sub-units and writeback.
// The issue controller connects through the slave modport; the environment drives the master side.
interface fpu_issue_ctrl_if #(
  parameter int N_UNITS = 4,
  parameter int DEPTH   = 4
);
  localparam int UID_W = $clog2(N_UNITS);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                       valid_in;
  logic                       ready_out;
  logic [UID_W-1:0]           unit_sel;
  logic [N_UNITS-1:0]         unit_valid;
  logic [N_UNITS-1:0]         unit_ready;
  logic [N_UNITS-1:0]         unit_done;
  logic [N_UNITS-1:0]         unit_ack;
  logic [N_UNITS-1:0][31:0]   unit_res;
  logic                       valid_out;
  logic                       ready_in;
  logic [31:0]                res_out;
  logic [CNT_W-1:0]           in_flight;

  modport master (
    output valid_in, unit_sel, unit_ready, unit_done, unit_res, ready_in,
    input  ready_out, unit_valid, unit_ack, valid_out, res_out, in_flight
  );

  modport slave (
    input  valid_in, unit_sel, unit_ready, unit_done, unit_res, ready_in,
    output ready_out, unit_valid, unit_ack, valid_out, res_out, in_flight
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// In-order issue/retire controller sharing one FPU request port across N_UNITS sub-units.
// A tag FIFO of unit IDs records issue order; only the oldest op's unit may retire.

module fpu_issue_lane #(
  parameter int LANE_ID = 0,
  parameter int UID_W   = 2
) (
  input  logic             issue_en,
  input  logic             valid_in,
  input  logic [UID_W-1:0] sel,
  input  logic [UID_W-1:0] head,
  input  logic             head_ok,
  input  logic             ack_en,
  input  logic             done,
  input  logic [31:0]      res,
  output logic             unit_valid,
  output logic             unit_ack,
  output logic             hit,
  output logic [31:0]      res_m
);
  logic is_sel;
  logic is_head;

  always_comb begin
    is_sel     = (sel == UID_W'(LANE_ID));
    is_head    = (head == UID_W'(LANE_ID));
    unit_valid = valid_in && issue_en && is_sel;
    // ack follows head + writeback ready; a unit only consumes it while its done is up
    unit_ack   = ack_en && is_head;
    hit        = head_ok && is_head && done;
    res_m      = hit ? res : 32'h0;
  end
endmodule

module fpu_issue_ctrl #(
  parameter int N_UNITS = 4,
  parameter int DEPTH   = 4
) (
  input logic          clk,
  input logic          reset,
  fpu_issue_ctrl_if.slave bus
);
  localparam int UID_W = $clog2(N_UNITS);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0][UID_W-1:0] tags_q, tags_d;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]            count_q, count_d;

  logic                        full, empty, sel_ok;
  logic                        issue_en, head_ok, ack_en;
  logic                        ready_out, issue, retire, valid_out;
  logic [UID_W-1:0]            head;
  logic [N_UNITS-1:0]          valid_v, ack_v, hit_v;
  logic [N_UNITS-1:0][31:0]    res_m;
  logic [31:0]                 res_or;

  always_comb begin
    full      = (count_q == CNT_W'(DEPTH));
    empty     = (count_q == '0);
    // unit IDs beyond N_UNITS stall forever rather than alias onto a real unit
    sel_ok    = (int'(bus.unit_sel) < N_UNITS);
    issue_en  = !reset && !full && sel_ok;
    ready_out = issue_en && bus.unit_ready[bus.unit_sel];
    issue     = bus.valid_in && ready_out;
    head      = tags_q[rd_ptr_q];
    head_ok   = !reset && !empty;
    ack_en    = head_ok && bus.ready_in;
  end

  for (genvar k = 0; k < N_UNITS; k++) begin : g_lane
    fpu_issue_lane #(.LANE_ID(k), .UID_W(UID_W)) u_lane (
      .issue_en   (issue_en),
      .valid_in   (bus.valid_in),
      .sel        (bus.unit_sel),
      .head       (head),
      .head_ok    (head_ok),
      .ack_en     (ack_en),
      .done       (bus.unit_done[k]),
      .res        (bus.unit_res[k]),
      .unit_valid (valid_v[k]),
      .unit_ack   (ack_v[k]),
      .hit        (hit_v[k]),
      .res_m      (res_m[k])
    );
  end

  always_comb begin
    res_or = 32'h0;
    for (int k = 0; k < N_UNITS; k++) res_or = res_or | res_m[k];
    valid_out = |hit_v;
    retire    = valid_out && bus.ready_in;
  end

  always_comb begin
    tags_d   = tags_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (issue) begin
      tags_d[wr_ptr_q] = bus.unit_sel;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (retire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(issue) - CNT_W'(retire);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tags_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      tags_q   <= tags_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign bus.ready_out  = ready_out;
  assign bus.unit_valid = valid_v;
  assign bus.unit_ack   = ack_v;
  assign bus.valid_out  = valid_out;
  assign bus.res_out    = res_or;
  assign bus.in_flight  = count_q;
endmodule
